// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between
// an instruction-fetch port and a data load/store port (fixed 3-cycle cadence).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic [31:0]           d_rdata,
    output logic                  d_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  mem_rstrb,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nx;
    logic        gnt_d, last_d, gnt_d_nx, start;
    logic [31:0] addr, wdata, i_data, d_data;
    logic [3:0]  wmask;
    logic        is_access, is_store;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    // D wins contention only when I was granted last
    always_comb begin
        start    = state == IDLE && (i_req || d_req);
        gnt_d_nx = d_req && (!i_req || !last_d);
        state_nx = start ? ACCESS : state == ACCESS ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt_d  <= 1'b0;
            last_d <= 1'b1;
            addr   <= '0;
            wdata  <= '0;
            wmask  <= '0;
            i_data <= '0;
            d_data <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                gnt_d  <= gnt_d_nx;
                last_d <= gnt_d_nx;
                addr   <= gnt_d_nx ? d_addr : i_addr;
                wdata  <= gnt_d_nx ? d_wdata : '0;
                wmask  <= gnt_d_nx ? d_wmask : '0;
            end
            if (i_ack)
                i_data <= mem_rdata;
            if (d_ack && !is_store)
                d_data <= mem_rdata;
        end
    end

    always_comb begin
        is_access = state == ACCESS;
        is_store  = |wmask;
        mem_addr  = is_access ? addr[ADDR_WIDTH+1:2] : '0;
        mem_rstrb = is_access && !is_store;
        mem_wmask = is_access ? wmask : '0;
        mem_wdata = is_access ? wdata : '0;
        i_ack     = state == RESP && !gnt_d;
        d_ack     = state == RESP && gnt_d;
        i_rdata   = i_ack ? mem_rdata : i_data;
        d_rdata   = (d_ack && !is_store) ? mem_rdata : d_data;
        busy      = state != IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written contention,
// reset-during-access and request-drop sequences against a behavioural memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_rstrb, busy;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [256];
    logic        init_done = 1'b0;

    typedef struct {
        bit          port_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [7:0]  exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    mem_arbiter #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // word k preloads to 0x1000_00kk except word 2, which holds an instruction
    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 256; k++)
                mem[k] <= (k == 2) ? 32'h00100093 : (32'h1000_0000 | 32'(k));
            init_done <= 1'b1;
        end else begin
            if (mem_rstrb)
                mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b])
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cyc = 0;
        bit got = 0;
        i_req   = !v.port_d;
        d_req   = v.port_d;
        i_addr  = v.port_d ? 32'h0 : v.addr;
        d_addr  = v.port_d ? v.addr : 32'h0;
        d_wdata = v.wdata;
        d_wmask = v.wmask;
        while (!got && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk($sformatf("v%0d mem_addr", n), {24'b0, mem_addr}, {24'b0, v.exp_maddr});
                chk($sformatf("v%0d mem_rstrb", n), {31'b0, mem_rstrb}, {31'b0, v.wmask == 4'b0});
                chk($sformatf("v%0d mem_wmask", n), {28'b0, mem_wmask}, {28'b0, v.wmask});
                if (v.wmask != 4'b0)
                    chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.wdata);
            end
            if (v.port_d ? d_ack : i_ack) begin
                got = 1;
                chk($sformatf("v%0d ack_cycle", n), cyc, 2);
                chk($sformatf("v%0d other_ack", n), {31'b0, v.port_d ? i_ack : d_ack}, 32'h0);
                chk($sformatf("v%0d rdata", n), v.port_d ? d_rdata : i_rdata, v.exp_rdata);
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        chk($sformatf("v%0d ack_seen", n), {31'b0, got}, 32'h1);
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d idle", n), {31'b0, busy}, 32'h0);
        chk($sformatf("v%0d rdata_hold", n), v.port_d ? d_rdata : i_rdata, v.exp_rdata);
    endtask

    initial begin
        vecs[0] = '{0, 32'h0000_0008, 32'h0,         4'b0000, 8'd2,   32'h0010_0093};
        vecs[1] = '{1, 32'h0000_000C, 32'hDEADBEEF,  4'b0011, 8'd3,   32'h0000_0000};
        vecs[2] = '{1, 32'h0000_000C, 32'h0,         4'b0000, 8'd3,   32'h1000_BEEF};
        vecs[3] = '{1, 32'h0000_0403, 32'h0,         4'b0000, 8'd0,   32'h1000_0000};
        vecs[4] = '{0, 32'h0000_0FFC, 32'h0,         4'b0000, 8'hFF,  32'h1000_00FF};
        vecs[5] = '{1, 32'h0000_0010, 32'hA5A5A5A5,  4'b1100, 8'd4,   32'h1000_0000};
        vecs[6] = '{1, 32'h0000_0010, 32'h0,         4'b0000, 8'd4,   32'hA5A5_0004};
        vecs[7] = '{0, 32'h0000_0010, 32'h0,         4'b0000, 8'd4,   32'hA5A5_0004};

        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst acks", {30'b0, i_ack, d_ack}, 32'h0);
        chk("rst mem_ctl", {27'b0, mem_rstrb, mem_wmask}, 32'h0);
        chk("rst mem_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst i_rdata", i_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 8; n++)
            run_vec(n, vecs[n]);

        // contention straight after reset: I, D, I, D with acks at 2, 5, 8, 11
        reset = 1'b0;
        #1;
        @(negedge clk) reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h08;
        d_req = 1'b1; d_addr = 32'h10; d_wmask = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr c%0d i_ack", c), {31'b0, i_ack}, {31'b0, c == 2 || c == 8});
            chk($sformatf("rr c%0d d_ack", c), {31'b0, d_ack}, {31'b0, c == 5 || c == 11});
            chk($sformatf("rr c%0d busy", c), {31'b0, busy}, {31'b0, c % 3 != 0});
            if (c == 2)
                chk("rr i_rdata", i_rdata, 32'h0010_0093);
            if (c == 5)
                chk("rr d_rdata", d_rdata, 32'hA5A5_0004);
        end
        i_req = 1'b0; d_req = 1'b0;

        // reset asserted while a store is in ACCESS
        d_req = 1'b1; d_addr = 32'h14; d_wdata = 32'hDEADBEEF; d_wmask = 4'b1111;
        @(posedge clk);
        #1;
        chk("midrst pre wmask", {28'b0, mem_wmask}, 32'hF);
        reset = 1'b0;
        #1;
        chk("midrst wmask", {28'b0, mem_wmask}, 32'h0);
        chk("midrst busy", {31'b0, busy}, 32'h0);
        d_req = 1'b0; d_wmask = 4'b0000;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst post c%0d", c), {30'b0, d_ack, busy}, 32'h0);
        end
        chk("midrst mem5", mem[5], 32'h1000_0005);

        // req held only for the sampling cycle, payload scrambled afterwards
        d_req = 1'b1; d_addr = 32'h0C; d_wmask = 4'b0000;
        @(posedge clk);
        #1;
        d_req = 1'b0; d_addr = 32'hFFFF_FFF0; d_wmask = 4'b1111;
        chk("drop mem_addr", {24'b0, mem_addr}, 32'h3);
        chk("drop mem_rstrb", {31'b0, mem_rstrb}, 32'h1);
        @(posedge clk);
        #1;
        chk("drop d_ack", {31'b0, d_ack}, 32'h1);
        chk("drop d_rdata", d_rdata, 32'h1000_BEEF);
        @(posedge clk);
        #1;
        chk("drop idle", {30'b0, d_ack, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
